// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
//   Shared definitions for the instruction fetch queue slice.
//   - Default geometry (depth, PC width, instruction width).
//   - Queue operation encoding used by the control process.
//   - Entry packing/field helpers: an entry is {pc, inst}, pc in the upper bits.
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

   localparam int unsigned FQ_DEPTH  = 4;
   localparam int unsigned FQ_ADDR_W = 32;
   localparam int unsigned FQ_INST_W = 32;

   // Entry width for a given PC/instruction width.
   function automatic int unsigned fq_entry_w(input int unsigned addr_w,
                                              input int unsigned inst_w);
      return addr_w + inst_w;
   endfunction

   // Pointer width for a given (power-of-two) depth.
   function automatic int unsigned fq_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Per-cycle queue operation chosen by the control logic.
   typedef enum logic [2:0] {
      FQ_OP_IDLE,
      FQ_OP_PUSH,
      FQ_OP_POP,
      FQ_OP_PUSH_POP,
      FQ_OP_DROP,
      FQ_OP_FLUSH
   } fq_op_e;

endpackage

// File: rtl/inst_fetch_queue_storage.sv
// -----------------------------------------------------------------------------
// fq_storage
//   DEPTH x ENTRY_W register array backing the fetch queue.
//   - Synchronous write port, asynchronous (combinational) read port.
//   - Asynchronous active-low reset clears every entry to zero.
// Ports
//   clk      in  rising-edge clock
//   rst      in  asynchronous active-low reset
//   wr_en    in  write entry wr_addr with wr_data at the next edge
//   wr_addr  in  write index
//   wr_data  in  entry to write
//   rd_addr  in  read index
//   rd_data  out entry at rd_addr (combinational)
// -----------------------------------------------------------------------------
module fq_storage
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = FQ_DEPTH,
   parameter int unsigned ENTRY_W = FQ_ADDR_W + FQ_INST_W,
   parameter int unsigned PTR_W   = fq_ptr_w(FQ_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [PTR_W-1:0]   wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic [PTR_W-1:0]   rd_addr,
   output logic [ENTRY_W-1:0] rd_data
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Decoupling queue between the PC/ROM fetch stage and decode.
//   - Captures {pc, instruction} pairs returned by the ROM (1-cycle latency).
//   - Presents them in order to decode through a valid/ready handshake.
//   - Back-pressures the PC via stall_pc, keeping one slot free for the ROM
//     read already in flight when the stall rises.
//   - Discards all queued and same-cycle entries on a branch flush.
// Configuration
//   FETCH_BYPASS_EN  defined: an empty queue forwards the incoming ROM word
//                    combinationally to decode (0-cycle latency); it is only
//                    stored if decode does not accept it that cycle.
//                    undefined: store-then-forward, 1-cycle latency.
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   if_valid     in   ROM data valid this cycle
//   if_pc        in   PC of the instruction on rom_data
//   rom_data     in   instruction word from ROM
//   flush        in   branch taken: drop queue contents and this cycle's input
//   id_ready     in   decode accepts the head entry this cycle
//   id_valid     out  head entry valid
//   id_pc        out  head entry PC
//   id_inst      out  head entry instruction
//   stall_pc     out  hold the PC (count >= DEPTH-1)
//   overflow_err out  sticky: a push arrived while full with no pop
// -----------------------------------------------------------------------------
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = FQ_DEPTH,
   parameter int unsigned ADDR_W = FQ_ADDR_W,
   parameter int unsigned INST_W = FQ_INST_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] rom_data,
   input  logic              flush,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              stall_pc,
   output logic              overflow_err
);

   localparam int unsigned PTR_W   = fq_ptr_w(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = fq_entry_w(ADDR_W, INST_W);

   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               ovf_q;

   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;
   logic               wr_en;

   logic               q_valid;
   logic               full;
   logic               bypass;
   logic               push;
   logic               pop;
   fq_op_e             op;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   fq_storage #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W),
      .PTR_W   (PTR_W)
   ) u_storage (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   assign wr_entry = {if_pc, rom_data};

   always_comb begin
      q_valid = (count != '0);
      full    = (count == CNT_W'(DEPTH));

      bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
      bypass = ~q_valid & if_valid & ~flush;
`endif

      id_valid = q_valid | bypass;
      id_pc    = bypass ? if_pc    : rd_entry[ENTRY_W-1 -: ADDR_W];
      id_inst  = bypass ? rom_data : rd_entry[INST_W-1:0];

      // A bypassed word accepted by decode is consumed without being stored.
      push = if_valid & ~flush & ~(bypass & id_ready);
      pop  = q_valid & id_ready & ~flush;

      op = FQ_OP_IDLE;
      if (flush) begin
         op = FQ_OP_FLUSH;
      end else if (push && pop) begin
         op = FQ_OP_PUSH_POP;
      end else if (push && full) begin
         op = FQ_OP_DROP;
      end else if (push) begin
         op = FQ_OP_PUSH;
      end else if (pop) begin
         op = FQ_OP_POP;
      end

      wr_en = (op == FQ_OP_PUSH) || (op == FQ_OP_PUSH_POP);
   end

   assign stall_pc     = (count >= CNT_W'(DEPTH - 1));
   assign overflow_err = ovf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
      end else begin
         unique case (op)
            FQ_OP_FLUSH: begin
               count  <= '0;
               rd_ptr <= wr_ptr;
            end
            FQ_OP_PUSH: begin
               count  <= count + CNT_W'(1);
               wr_ptr <= ptr_inc(wr_ptr);
            end
            FQ_OP_POP: begin
               count  <= count - CNT_W'(1);
               rd_ptr <= ptr_inc(rd_ptr);
            end
            FQ_OP_PUSH_POP: begin
               wr_ptr <= ptr_inc(wr_ptr);
               rd_ptr <= ptr_inc(rd_ptr);
            end
            FQ_OP_DROP: begin
               ovf_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Scoreboard bench: the driver models the queue as a list of accepted
//   {pc, inst} words and pushes each accepted word as an expected output;
//   the monitor pops and compares on every decode handshake.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] rom_data;
   logic        flush;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        stall_pc;
   logic        overflow_err;

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (32),
      .INST_W (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .rom_data     (rom_data),
      .flush        (flush),
      .id_ready     (id_ready),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_inst      (id_inst),
      .stall_pc     (stall_pc),
      .overflow_err (overflow_err)
   );

   int          total = 0;
   int          bad   = 0;
   bit          mon_en = 0;

   // Reference model state
   logic [63:0] exp_q[$];
   int          cnt = 0;
   bit          ovf_s = 0;
   bit          exp_valid = 0;
   bit          exp_stall = 0;
   bit          exp_ovf = 0;

   logic [31:0] next_pc = 32'h8000_0000;
   logic [31:0] flush_target = 32'h8000_0100;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Applies the queue rules to the inputs driven for the current cycle.
   task automatic model_step();
      bit byp;
      bit pop_m;
      byp = 0;
`ifdef FETCH_BYPASS_EN
      byp = (cnt == 0) && if_valid && !flush;
`endif
      exp_valid = (cnt != 0) || byp;
      exp_stall = (cnt >= DEPTH - 1);
      exp_ovf   = ovf_s;
      if (flush) begin
         exp_q.delete();
         cnt = 0;
      end else begin
         pop_m = (cnt != 0) && id_ready;
         if (if_valid) begin
            if (byp && id_ready) begin
               exp_q.push_back({if_pc, rom_data});
            end else if (cnt < DEPTH || pop_m) begin
               exp_q.push_back({if_pc, rom_data});
               cnt++;
            end else begin
               ovf_s = 1;
            end
         end
         if (pop_m) cnt--;
      end
   endtask

   task automatic drive(input bit v, input bit fl, input bit rdy);
      @(posedge clk);
      #1;
      if_valid = v;
      if_pc    = next_pc;
      rom_data = $urandom;
      flush    = fl;
      id_ready = rdy;
      model_step();
      if (fl) next_pc = flush_target;
      else if (v) next_pc = next_pc + 32'd4;
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      if_valid = 0; flush = 0; id_ready = 0;
      exp_q.delete();
      cnt = 0; ovf_s = 0;
      exp_valid = 0; exp_stall = 0; exp_ovf = 0;
      #1;
      chk("midrst_valid", {31'd0, id_valid}, 32'd0);
      chk("midrst_pc", id_pc, 32'd0);
      chk("midrst_ovf", {31'd0, overflow_err}, 32'd0);
      #1;
      rst = 1'b1;
   endtask

   // Monitor: compares status every cycle and head data on each handshake.
   always @(negedge clk) begin
      logic [63:0] e;
      if (mon_en && rst) begin
         chk("id_valid", {31'd0, id_valid}, {31'd0, exp_valid});
         chk("stall_pc", {31'd0, stall_pc}, {31'd0, exp_stall});
         chk("overflow_err", {31'd0, overflow_err}, {31'd0, exp_ovf});
         if (id_valid && id_ready && !flush) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_empty: got=handshake want=no_entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc", id_pc, e[63:32]);
               chk("id_inst", id_inst, e[31:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      if_valid = 0; if_pc = '0; rom_data = '0; flush = 0; id_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_inst", id_inst, 32'd0);
      chk("rst_stall", {31'd0, stall_pc}, 32'd0);
      chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
      rst = 1'b1;
      mon_en = 1;

      // In-order stream with decode always ready.
      next_pc = 32'h8000_0000;
      repeat (4) drive(1, 0, 1);
      repeat (2) drive(0, 0, 1);

      // Fill with decode stalled; fifth word overflows.
      repeat (4) drive(1, 0, 0);
      drive(1, 0, 0);
      repeat (2) drive(0, 0, 0);

      // Full queue, push and pop together across pointer wrap.
      repeat (6) drive(1, 0, 1);

      // Drain to two entries, then flush with a word arriving.
      repeat (2) drive(0, 0, 1);
      drive(0, 0, 0);
      flush_target = 32'h8000_0100;
      drive(1, 1, 0);
      drive(1, 0, 1);
      repeat (3) drive(0, 0, 1);

      // Asynchronous reset mid-operation.
      repeat (3) drive(1, 0, 0);
      mid_reset();

      // Single word into an empty queue with decode ready.
      next_pc = 32'h8000_0040;
      drive(1, 0, 1);
      repeat (2) drive(0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         flush_target = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'h8000_0000;
         drive($urandom_range(0, 99) < 70,
               $urandom_range(0, 99) < 5,
               $urandom_range(0, 99) < 60);
      end

      repeat (8) drive(0, 0, 1);
      @(posedge clk);
      #1;
      chk("drained", exp_q.size(), 32'd0);
      mon_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
